// File: rtl/logarithmic_afpm.sv
// Approximate FP16 multiplier (Mitchell log approximation) behind the Tiny Tapeout pin wrapper.
// Operands arrive byte-serially over two clocks; the product leaves byte-serially over the next two.
module logarithmic_afpm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        LO     = 2'd0,
        HI     = 2'd1,
        OUT_LO = 2'd2,
        OUT_HI = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [7:0]  a_lo, b_lo;
    logic [15:0] prod, prod_next;

    logic [15:0] op_a, op_b;
    logic [4:0]  a_exp, b_exp;
    logic [9:0]  a_man, b_man;
    logic        sign, a_max, b_max, a_zero, b_zero, is_nan;
    logic [15:0] sum, diff;

    logic unused_ena;
    assign unused_ena = ena;

    assign uio_out = '0;
    assign uio_oe  = '0;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= LO;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LO:      state_next = HI;
            HI:      state_next = OUT_LO;
            OUT_LO:  state_next = OUT_HI;
            OUT_HI:  state_next = LO;
            default: state_next = LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_lo   <= '0;
            b_lo   <= '0;
            prod   <= '0;
            uo_out <= '0;
        end else begin
            case (state)
                LO: begin
                    a_lo <= ui_in;
                    b_lo <= uio_in;
                end
                HI:      prod   <= prod_next;
                OUT_LO:  uo_out <= prod[7:0];
                OUT_HI:  uo_out <= prod[15:8];
                default: ;
            endcase
        end
    end

    // Adding the magnitude bit patterns adds the log2 values; a mantissa carry bumps the exponent.
    always_comb begin
        op_a   = {ui_in, a_lo};
        op_b   = {uio_in, b_lo};
        sign   = op_a[15] ^ op_b[15];
        a_exp  = op_a[14:10];
        b_exp  = op_b[14:10];
        a_man  = op_a[9:0];
        b_man  = op_b[9:0];
        a_max  = (a_exp == 5'h1F);
        b_max  = (b_exp == 5'h1F);
        a_zero = (a_exp == 5'h00);
        b_zero = (b_exp == 5'h00);
        is_nan = (a_max && (a_man != '0)) || (b_max && (b_man != '0)) ||
                 (a_max && b_zero) || (b_max && a_zero);
        sum    = {1'b0, op_a[14:0]} + {1'b0, op_b[14:0]};
        diff   = sum - 16'h3C00;

        if (is_nan) begin
            prod_next = 16'h7E00;
        end else if (a_max || b_max) begin
            prod_next = {sign, 15'h7C00};
        end else if (a_zero || b_zero) begin
            prod_next = {sign, 15'h0000};
        end else if (sum < 16'h4000) begin
            prod_next = {sign, 15'h0000};
        end else if (diff >= 16'h7C00) begin
            prod_next = {sign, 15'h7C00};
        end else begin
            prod_next = {sign, diff[14:0]};
        end
    end

endmodule

// File: tb/tb_logarithmic_afpm.sv
// Directed bench for logarithmic_afpm: expected product bytes are queued at stimulus time
// and popped when the corresponding byte appears on uo_out.
module tb_logarithmic_afpm;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  last_out;

    logarithmic_afpm dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference of the approximate product, in integer arithmetic.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        int   ea, eb, ma, mb, s, r;
        logic sg;
        logic [15:0] rv;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ma = int'(a[9:0]);
        mb = int'(b[9:0]);
        sg = a[15] ^ b[15];
        if ((ea == 31 && ma != 0) || (eb == 31 && mb != 0)) return 16'h7E00;
        if ((ea == 31 && eb == 0) || (eb == 31 && ea == 0)) return 16'h7E00;
        if (ea == 31 || eb == 31) return {sg, 15'h7C00};
        if (ea == 0 || eb == 0) return {sg, 15'h0000};
        s = int'(a[14:0]) + int'(b[14:0]);
        if (s < 16384) return {sg, 15'h0000};
        r = s - 15360;
        if (r >= 31744) return {sg, 15'h7C00};
        rv = r[15:0];
        return {sg, rv[14:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] want;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: got %h expected <queued byte>", tag, uo_out);
        end else begin
            want = exp_q.pop_front();
            check(tag, uo_out, want);
        end
    endtask

    // One full transaction starting in LO; 'want' is the expected 16-bit product.
    task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] want);
        exp_q.push_back(want[7:0]);
        exp_q.push_back(want[15:8]);
        ui_in  = a[7:0];
        uio_in = b[7:0];
        tick();
        check({tag, "_hold"}, uo_out, last_out);
        ui_in  = a[15:8];
        uio_in = b[15:8];
        tick();
        ui_in  = 8'($urandom);
        uio_in = 8'($urandom);
        tick();
        pop_check({tag, "_lo"});
        tick();
        pop_check({tag, "_hi"});
        last_out = want[15:8];
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst_n    = 1'b1;
        ena      = 1'b1;
        ui_in    = 8'hFF;
        uio_in   = 8'hFF;
        last_out = 8'h00;
        tick();
        tick();
        tick();
        check("reset_uo_out", uo_out, 8'h00);
        check("uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'h00);

        rst_n = 1'b0;
        run("nominal",   16'h48B9, 16'h3F7B, 16'h4C34);
        run("identity",  16'h3C00, 16'h3C00, 16'h3C00);
        run("sign",      16'hC000, 16'h4000, 16'hC400);
        run("zero",      16'h0000, 16'h4500, 16'h0000);
        run("flush",     16'h0400, 16'h0400, 16'h0000);
        run("neg_zero",  16'h8000, 16'h3C00, 16'h8000);
        run("overflow",  16'h7800, 16'h7800, 16'h7C00);
        run("neg_inf",   16'hFC00, 16'h4000, 16'hFC00);
        run("nan_in",    16'h7E00, 16'h3C00, 16'h7E00);
        run("inf_zero",  16'h7C00, 16'h0000, 16'h7E00);
        run("max_norm",  16'h7BFF, 16'h3C00, 16'h7BFF);
        run("min_norm",  16'h0400, 16'h3800, 16'h0000);
        run("edge_norm", 16'h0400, 16'h3C00, 16'h0400);
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run("random", ra, rb, model(ra, rb));
        end

        // Abort after the low bytes: product register must not leak the stale operand.
        run("pre_reset", 16'h4500, 16'h4200, 16'h4B00);
        ui_in  = 8'h00;
        uio_in = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_reset", uo_out, 8'h00);
        rst_n    = 1'b0;
        last_out = 8'h00;
        run("post_reset", 16'h3C00, 16'h3C00, 16'h3C00);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain: got %0d expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
